// File: rtl/dense_layer_pkg.sv
// Shared types and fixed-point helpers for the dense layer MAC.
package dense_layer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    OUT
  } state_e;

  localparam int MAX_W = 64;

  // Clamp a wide signed value into the range of a signed `width`-bit word.
  function automatic logic signed [MAX_W-1:0] saturate(
    input logic signed [MAX_W-1:0] v,
    input int unsigned             width
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [MAX_W-1:0] relu(
    input logic signed [MAX_W-1:0] v,
    input logic                    en
  );
    return (en && (v < 0)) ? '0 : v;
  endfunction

endpackage

// File: rtl/dense_layer_mac_if.sv
// Streaming sample input and result-vector output of the dense layer.
interface dense_layer_mac_if #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/neuron_post.sv
// Per-neuron output stage: rescale, add bias, saturate, optional ReLU.
module neuron_post
  import dense_layer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 36
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic                     relu_en_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [MAX_W-1:0] sum_w;

  // Arithmetic shift floors toward minus infinity, dropping the product fraction.
  assign shifted = acc_i >>> FRAC_W;
  assign sum_w   = {{(MAX_W-ACC_W){shifted[ACC_W-1]}}, shifted}
                 + {{(MAX_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};
  assign res_o   = DATA_W'(relu(saturate(sum_w, DATA_W), relu_en_i));

endmodule

// File: rtl/dense_layer_mac.sv
// Fully-connected layer: streamed samples are MACed against loadable weights in N_OUT parallel lanes.
module dense_layer_mac
  import dense_layer_pkg::*;
#(
  parameter int N_OUT  = 10,
  parameter int N_IN   = 16,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(N_IN)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          w_we,
  input  logic [$clog2(N_OUT*N_IN)-1:0] w_addr,
  input  logic signed [DATA_W-1:0]      w_data,
  input  logic [N_OUT*DATA_W-1:0]       bias,
  input  logic                          relu_en,
  dense_layer_mac_if.slave              bus,
  output logic                          busy
);

  localparam int ADDR_W = $clog2(N_OUT*N_IN);
  localparam int K_W    = $clog2(N_IN);

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic                     in_ready;
  logic                     out_valid;
  logic                     acc_load;
  logic                     acc_add;
  logic                     out_load;
  logic                     w_en;
  logic signed [DATA_W-1:0] w_q [N_OUT][N_IN];
  logic [N_OUT*DATA_W-1:0]  post_flat;
  logic [N_OUT*DATA_W-1:0]  out_q;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    out_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_load = 1'b1;
          k_d      = K_W'(1);
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_add = 1'b1;
          if (k_q == K_W'(N_IN-1)) begin
            k_d     = '0;
            state_d = FINISH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      FINISH: begin
        out_load = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (out_load) out_q <= post_flat;
    end
  end

  assign w_en = w_we && (state_q == IDLE);

  // NOTE: the weight array deliberately has no reset so loaded weights
  // survive an abort and the storage maps onto plain registers.
  always_ff @(posedge clk) begin
    for (int n = 0; n < N_OUT; n++) begin
      for (int k = 0; k < N_IN; k++) begin
        if (w_en && (w_addr == ADDR_W'(n*N_IN + k))) w_q[n][k] <= w_data;
      end
    end
  end

  for (genvar n = 0; n < N_OUT; n++) begin : g_lane
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = bus.in_data * w_q[n][k_q];
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // The first sample overwrites the lane so no clear cycle is needed between vectors.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         acc_q <= '0;
      else if (acc_load) acc_q <= prod_ext;
      else if (acc_add)  acc_q <= acc_q + prod_ext;
    end

    neuron_post #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_post (
      .acc_i     (acc_q),
      .bias_i    (bias[n*DATA_W +: DATA_W]),
      .relu_en_i (relu_en),
      .res_o     (post_flat[n*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dense_layer_mac.sv
// Self-checking bench for dense_layer_mac: directed table plus randomized vectors against an arithmetic model.
module tb_dense_layer_mac;

  localparam int N_OUT  = 10;
  localparam int N_IN   = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 2*DATA_W + $clog2(N_IN);
  localparam int ADDR_W = $clog2(N_OUT*N_IN);
  localparam int VEC_W  = N_OUT*DATA_W;

  typedef struct packed {
    logic signed [15:0]      w_all;
    logic [N_IN-1:0][15:0]   xs;
    logic [3:0]              bn;
    logic signed [15:0]      bv;
    logic                    relu;
    logic signed [15:0]      exp_n;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     w_we;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic [VEC_W-1:0]         bias;
  logic                     relu_en;
  logic                     busy;

  dense_layer_mac_if #(.N_OUT(N_OUT), .DATA_W(DATA_W)) bus ();

  dense_layer_mac #(
    .N_OUT (N_OUT), .N_IN (N_IN), .DATA_W (DATA_W), .FRAC_W (FRAC_W), .ACC_W (ACC_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .bias    (bias),
    .relu_en (relu_en),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int wt_m   [N_OUT][N_IN];
  int bias_m [N_OUT];
  bit relu_m;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Reference: dot product, floor divide by 2^FRAC_W, add bias, clamp, ReLU.
  function automatic logic [VEC_W-1:0] model_vec(input int xs[N_IN]);
    logic [VEC_W-1:0] r;
    longint           acc;
    longint           s;
    r = '0;
    for (int n = 0; n < N_OUT; n++) begin
      acc = 0;
      for (int k = 0; k < N_IN; k++) acc += longint'(xs[k]) * longint'(wt_m[n][k]);
      s = (acc >>> FRAC_W) + longint'(bias_m[n]);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu_m && s < 0) s = 0;
      r[n*DATA_W +: DATA_W] = DATA_W'(s);
    end
    return r;
  endfunction

  function automatic vec_t mk(input int w, input int x0, input int x1, input int x2, input int x3,
                              input int bn, input int bv, input bit relu, input int exp_n);
    vec_t v;
    v.w_all = 16'(w);
    v.xs[0] = 16'(x0);
    v.xs[1] = 16'(x1);
    v.xs[2] = 16'(x2);
    v.xs[3] = 16'(x3);
    v.bn    = 4'(bn);
    v.bv    = 16'(bv);
    v.relu  = relu;
    v.exp_n = 16'(exp_n);
    return v;
  endfunction

  task automatic write_w(input int n, input int k, input int v);
    w_we   = 1'b1;
    w_addr = ADDR_W'(n*N_IN + k);
    w_data = DATA_W'(v);
    @(negedge clk);
    w_we   = 1'b0;
    wt_m[n][k] = v;
  endtask

  task automatic write_all(input int v, input bit rnd);
    for (int n = 0; n < N_OUT; n++)
      for (int k = 0; k < N_IN; k++) write_w(n, k, rnd ? rnd16() : v);
  endtask

  task automatic apply_cfg();
    for (int n = 0; n < N_OUT; n++) bias[n*DATA_W +: DATA_W] = DATA_W'(bias_m[n]);
    relu_en = relu_m;
  endtask

  task automatic send_samples(input int xs[N_IN], input int from, input int to, input int max_gap);
    int g;
    int wd;
    for (int k = from; k <= to; k++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(xs[k]);
      wd = 0;
      while (!bus.in_ready && wd < 20) begin
        @(negedge clk);
        wd++;
      end
      check("in_ready_for_sample", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Called at the negedge right after the last accept; returns negedges until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_out(input string tag, input int xs[N_IN]);
    check_vec(tag, bus.out_data, model_vec(xs));
    check("in_ready_low_in_out", bus.in_ready, 0);
    check("busy_in_out", busy, 1);
  endtask

  task automatic handshake();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_hs", bus.in_ready, 1);
    check("out_valid_after_hs", bus.out_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  task automatic random_cfg(output int xs[N_IN]);
    for (int k = 0; k < N_IN; k++) xs[k] = rnd16();
    for (int n = 0; n < N_OUT; n++) bias_m[n] = rnd16();
    relu_m = 1'($urandom_range(1, 0));
    apply_cfg();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   xs[N_IN];
    int   lat;
    int   cur_w;
    bit   have_w;

    rstn = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; bias = '0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    relu_m = 1'b0;
    for (int n = 0; n < N_OUT; n++) bias_m[n] = 0;

    repeat (2) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", busy, 0);
    check_vec("reset_out_data", bus.out_data, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results for one neuron each.
    tbl[0] = mk(256,    256,   256,   256,   256,   1, 5,    1, 1029);
    tbl[1] = mk(256,    256,   0,     0,     0,     3, -300, 1, 0);
    tbl[2] = mk(256,    256,   0,     0,     0,     3, -300, 0, -44);
    tbl[3] = mk(32767,  32767, 32767, 32767, 32767, 0, 0,    0, 32767);
    tbl[4] = mk(-32768, 32767, 32767, 32767, 32767, 0, 0,    0, -32768);
    tbl[5] = mk(-32768, 32767, 32767, 32767, 32767, 0, 0,    1, 0);
    have_w = 1'b0;
    cur_w  = 0;
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      if (!have_w || int'(v.w_all) != cur_w) begin
        cur_w  = int'(v.w_all);
        have_w = 1'b1;
        write_all(cur_w, 1'b0);
      end
      for (int n = 0; n < N_OUT; n++) bias_m[n] = 0;
      bias_m[int'(v.bn)] = int'(v.bv);
      relu_m = v.relu;
      apply_cfg();
      for (int k = 0; k < N_IN; k++) xs[k] = int'($signed(v.xs[k]));
      send_samples(xs, 0, N_IN-1, 0);
      check("tbl_out_valid_in_finish", bus.out_valid, 0);
      wait_valid(lat);
      check("tbl_latency", lat, 2);
      check("tbl_neuron", $signed(bus.out_data[int'(v.bn)*DATA_W +: DATA_W]), v.exp_n);
      expect_out("tbl_vector", xs);
      handshake();
    end

    // Weight writes during ACCUM are dropped; an IDLE write in the accept cycle lands after use.
    write_all(256, 1'b0);
    for (int n = 0; n < N_OUT; n++) bias_m[n] = 0;
    relu_m = 1'b0;
    apply_cfg();
    xs = '{100, 200, 300, 400};
    send_samples(xs, 0, 0, 0);
    w_we = 1'b1; w_addr = ADDR_W'(2*N_IN + 3); w_data = 16'sd512;
    @(negedge clk);
    w_we = 1'b0;
    send_samples(xs, 1, N_IN-1, 0);
    wait_valid(lat);
    check("accum_write_latency", lat, 2);
    check("accum_write_ignored", $signed(bus.out_data[2*DATA_W +: DATA_W]), 1000);
    expect_out("accum_write_vec", xs);
    handshake();

    check("idle_ready_before_write", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = DATA_W'(xs[0]);
    w_we = 1'b1; w_addr = ADDR_W'(2*N_IN + 0); w_data = 16'sd768;
    @(negedge clk);
    w_we = 1'b0;
    send_samples(xs, 1, N_IN-1, 0);
    wait_valid(lat);
    check("idle_write_old_weight", $signed(bus.out_data[2*DATA_W +: DATA_W]), 1000);
    expect_out("idle_write_vec", xs);
    handshake();
    wt_m[2][0] = 768;
    send_samples(xs, 0, N_IN-1, 0);
    wait_valid(lat);
    check("idle_write_new_weight", $signed(bus.out_data[2*DATA_W +: DATA_W]), 1200);
    expect_out("new_weight_vec", xs);
    handshake();

    // Random weights and vectors with input gaps and a stalled output.
    write_all(0, 1'b1);
    for (int it = 0; it < 6; it++) begin
      random_cfg(xs);
      send_samples(xs, 0, N_IN-1, 3);
      wait_valid(lat);
      check("gap_latency", lat, 2);
      for (int c = 0; c < 5; c++) begin
        check_vec("hold_out_data", bus.out_data, model_vec(xs));
        check("hold_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(rnd16());
        for (int n = 0; n < N_OUT; n++) bias[n*DATA_W +: DATA_W] = 16'($urandom);
        relu_en = ~relu_en;
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      expect_out("gap_vec_after_hold", xs);
      handshake();
      apply_cfg();
      send_samples(xs, 0, N_IN-1, 0);
      wait_valid(lat);
      check("gapless_latency", lat, 2);
      expect_out("gapless_vec", xs);
      handshake();
    end

    // Reset mid-ACCUM aborts the vector; weights survive.
    random_cfg(xs);
    send_samples(xs, 0, 1, 0);
    check("busy_mid_accum", busy, 1);
    rstn = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_output", bus.out_valid, 0);
    end
    random_cfg(xs);
    send_samples(xs, 0, N_IN-1, 0);
    wait_valid(lat);
    check("post_abort_latency", lat, 2);
    expect_out("post_abort_vec", xs);
    handshake();

    // Reset while presenting a result drops out_valid at once.
    random_cfg(xs);
    send_samples(xs, 0, N_IN-1, 0);
    wait_valid(lat);
    expect_out("pre_reset_out_vec", xs);
    #2;
    rstn = 1'b0;
    #1;
    check("out_reset_out_valid", bus.out_valid, 0);
    check_vec("out_reset_out_data", bus.out_data, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    random_cfg(xs);
    send_samples(xs, 0, N_IN-1, 0);
    wait_valid(lat);
    expect_out("post_out_reset_vec", xs);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dense_layer_mac.md
# dense_layer_mac

Parametrised fully-connected layer: N_OUT neurons share one streamed input vector of N_IN fixed-point samples, each accepted sample being multiplied against a per-neuron weight and accumulated in parallel across all neurons. After the last sample, each neuron adds its bias, rescales, saturates and optionally applies ReLU. The result vector is then presented on a valid/ready output port. The block generalises the fixed ten-neuron layer with hard-wired weights to a configurable layer with loadable weights, input/output flow control and an activation bypass, so layers can be chained.

## Interface
- N_OUT, 10, neuron count
- N_IN, 16, input vector length (≥2)
- DATA_W, 16, signed sample/weight/bias/result width
- FRAC_W, 8, fractional bits of samples and weights (Q(DATA_W-FRAC_W).FRAC_W)
- ACC_W, 2*DATA_W+$clog2(N_IN), accumulator width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(N_OUT*N_IN)  weight index = n*N_IN + k
- w_data  in  DATA_W  signed weight
- bias  in  N_OUT*DATA_W  flattened signed biases, neuron n at [n*DATA_W +: DATA_W]
- relu_en  in  1  1 = ReLU, 0 = linear output
- in_valid / in_ready  in / out  1  input sample handshake
- in_data  in  DATA_W  signed sample
- out_valid / out_ready  out / in  1  result vector handshake
- out_data  out  N_OUT*DATA_W  flattened signed results, same packing as bias
- busy  out  1  high in ACCUM, FINISH or OUT

## Operation
- States: IDLE, ACCUM, FINISH, OUT.
- IDLE: in_ready=1. A weight write is applied when w_we=1. On an accepted sample, set acc[n] = x*w[n][0], k=1, and go to ACCUM.
- ACCUM: in_ready=1; weight writes are ignored. On an accepted sample, acc[n] += x*w[n][k] and k++. The sample with k=N_IN-1 moves the state to FINISH. Gaps in in_valid stall without loss.
- FINISH: in_ready=0; bias and relu_en are sampled here.
  - r = (acc[n] >>> FRAC_W), arithmetic shift, truncating toward −∞.
  - s = r + sign-extended bias[n].
  - Saturate s to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - If relu_en and the result is negative, force 0.
  - Register into out_data; go to OUT.
- OUT: out_valid=1; out_data is held stable and in_ready=0 until out_ready. The handshake cycle returns the state to IDLE.
- Products are full 2*DATA_W width, sign-extended to ACC_W. Accumulation never wraps within N_IN terms.
- Weight storage is an N_OUT×N_IN register array. Its contents are undefined after reset and not cleared by reset.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, k=0, accumulators=0.
- Throughput: one sample per cycle when in_valid is held high.
- Latency: the last sample is accepted at edge t; out_valid is high after edge t+1. Minimum vector period is N_IN+2 cycles with out_ready held high.
- out_valid && out_ready at edge u means in_ready is high after u. A new vector is never accepted in the same cycle as the output handshake.
- A weight write and a sample accept in the same IDLE cycle: the sample uses the old weight, and the write still lands.
- Deasserting rstn mid-ACCUM or in OUT aborts the vector immediately: partial sums are lost, out_valid drops asynchronously, and weights are preserved.
- bias and relu_en changes outside FINISH have no effect on the vector in flight.

## Structure
- Package dense_layer_pkg:
  - state enum {IDLE, ACCUM, FINISH, OUT}
  - saturate/relu helper functions parametrised by width
- One sub-module, neuron_post (shift, bias add, saturate, ReLU, combinational), instantiated N_OUT times in a generate loop.
- Top-level files hold the FSM, counter, weight array and MAC lanes.

## Test plan
All scenarios use N_OUT=10, N_IN=4, DATA_W=16, FRAC_W=8.
- All weights 256, samples {256,256,256,256}, bias1=5, relu_en=1 -> out n1 = 1029; out_valid one cycle after the 4th accept.
- Same weights, samples {256,0,0,0}, bias3=−300, relu_en=1 -> n3 = 0. Rerun with relu_en=0 -> n3 = −44.
- All weights 32767, samples 32767×4, bias 0 -> every output 32767. Weights −32768 with the same samples -> −32768 linear, 0 with ReLU.
- Random in_valid gaps with out_ready held low for 5 cycles -> results match the gapless run; out_data is stable while waiting; in_ready=0 until the handshake.
- rstn pulsed after 2 accepts -> out_valid stays 0. A fresh 4-sample vector then produces correct results without rewriting weights.
- w_we asserted during ACCUM -> weight unchanged. The same write in the accept cycle in IDLE -> the current vector uses the old weight, and the next vector uses the new one.
